// File: rtl/vending_machine_ctrl.sv
// Single-product vending controller: collects nickel/dime/quarter credit up to PRICE, vends with a
// dispenser handshake, returns change or refund as one valued strobe, and tracks stock.
module vending_machine_ctrl #(
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned PRICE      = 4,
    parameter int unsigned V_NICKLE   = 1,
    parameter int unsigned V_DIME     = 2,
    parameter int unsigned V_QUARTER  = 5,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_nickle,
    input  logic                i_dime,
    input  logic                i_quarter,
    input  logic                i_cancel,
    input  logic                i_restock,
    input  logic                i_disp_ack,
    output logic                o_soda,
    output logic [CREDIT_W-1:0] o_change,
    output logic                o_change_vld,
    output logic                o_coin_rej,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [STOCK_W-1:0]  o_stock,
    output logic                o_sold_out
);

    localparam int unsigned MaxCredit = (2 ** CREDIT_W) - 1;

    if (PRICE < 1 || PRICE > MaxCredit) begin : g_price_chk
        $error("PRICE must lie in 1..2**CREDIT_W-1");
    end
    if (STOCK_INIT > (2 ** STOCK_W) - 1) begin : g_stock_chk
        $error("STOCK_INIT does not fit in STOCK_W bits");
    end

    localparam logic [CREDIT_W-1:0] PriceC     = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ValNickle  = CREDIT_W'(V_NICKLE);
    localparam logic [CREDIT_W-1:0] ValDime    = CREDIT_W'(V_DIME);
    localparam logic [CREDIT_W-1:0] ValQuarter = CREDIT_W'(V_QUARTER);
    localparam logic [STOCK_W-1:0]  StockInitC = STOCK_W'(STOCK_INIT);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StVend,
        StChange,
        StRefund
    } state_e;

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [STOCK_W-1:0]    stock_q, stock_d;

    logic                  coin_any;
    logic                  coin_valid;
    logic [CREDIT_W-1:0]   coin_val;
    logic [CREDIT_W:0]     credit_sum;
    logic                  overflow;
    logic                  sold_out;

    assign coin_any   = i_nickle | i_dime | i_quarter;
    assign coin_valid = $onehot({i_quarter, i_dime, i_nickle});
    assign sold_out   = (stock_q == '0);

    always_comb begin
        coin_val = '0;
        unique case ({i_quarter, i_dime, i_nickle})
            3'b001:  coin_val = ValNickle;
            3'b010:  coin_val = ValDime;
            3'b100:  coin_val = ValQuarter;
            default: coin_val = '0;
        endcase
    end

    // Extra MSB catches the carry out of the credit register.
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign overflow   = credit_sum[CREDIT_W];

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        stock_d      = stock_q;
        o_soda       = 1'b0;
        o_change     = '0;
        o_change_vld = 1'b0;
        o_coin_rej   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_restock) begin
                    stock_d = StockInitC;
                end
                if (coin_any) begin
                    if (!coin_valid || sold_out || overflow) begin
                        o_coin_rej = 1'b1;
                    end else begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = (credit_sum[CREDIT_W-1:0] >= PriceC) ? StVend : StCollect;
                    end
                end
            end
            StCollect: begin
                if (i_cancel) begin
                    o_coin_rej = coin_any;
                    state_d    = StRefund;
                end else if (coin_any) begin
                    if (!coin_valid || overflow) begin
                        o_coin_rej = 1'b1;
                    end else begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        if (credit_sum[CREDIT_W-1:0] >= PriceC) begin
                            state_d = StVend;
                        end
                    end
                end
            end
            StVend: begin
                o_soda     = 1'b1;
                o_coin_rej = coin_any;
                // Stock is known non-zero here: VEND is only reachable after an accepted coin.
                if (i_disp_ack) begin
                    stock_d = stock_q - STOCK_W'(1);
                    if (credit_q > PriceC) begin
                        state_d = StChange;
                    end else begin
                        state_d  = StIdle;
                        credit_d = '0;
                    end
                end
            end
            StChange: begin
                o_change     = credit_q - PriceC;
                o_change_vld = 1'b1;
                o_coin_rej   = coin_any;
                credit_d     = '0;
                state_d      = StIdle;
            end
            StRefund: begin
                o_change     = credit_q;
                o_change_vld = 1'b1;
                o_coin_rej   = coin_any;
                credit_d     = '0;
                state_d      = StIdle;
            end
            default: begin
                state_d  = StIdle;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            credit_q <= '0;
            stock_q  <= StockInitC;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
        end
    end

    assign o_credit   = credit_q;
    assign o_stock    = stock_q;
    assign o_sold_out = sold_out;

endmodule
